// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register bank and its readers.
package reg_bank_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } rsp_state_t;

endpackage

// File: rtl/reg_bank_storage.sv
// DEPTH x WIDTH enablable registers, async clear, combinational read mux.
module reg_bank_storage
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    // One extra bit so DEPTH itself is representable when it is a power of 2.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];

    logic wr_in_rng;
    logic rd_in_rng;

    assign wr_in_rng = ({1'b0, wr_addr_i} < DEPTH_W);
    assign rd_in_rng = ({1'b0, rd_addr_i} < DEPTH_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else if (wr_en_i && wr_in_rng) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_in_rng) begin
            rd_data_o = regs_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/reg_bank_read_responder.sv
// Register bank with valid/ready read port and one-entry response buffer.
// Define REG_BANK_READ_FWD_EN for write-first forwarding on same-address hits.
module reg_bank_read_responder
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    rsp_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cap_data;
    logic             req_in_rng;
    logic             accept;

    reg_bank_storage #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (req_addr),
        .rd_data_o (rd_data)
    );

    assign req_in_rng = ({1'b0, req_addr} < DEPTH_W);
    assign req_ready  = (state_q == IDLE) || rsp_ready;
    assign accept     = req_valid && req_ready;

`ifdef REG_BANK_READ_FWD_EN
    always_comb begin
        cap_data = rd_data;
        if (wr_en && (wr_addr == req_addr) && req_in_rng) begin
            cap_data = wr_data;
        end
    end
`else
    // Read-first: the register value before this cycle's write.
    assign cap_data = rd_data;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            data_d = req_in_rng ? cap_data : '0;
            err_d  = !req_in_rng;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_reg_bank_read_responder.sv
// Directed bench with a transaction-level model of the register bank.
module tb_reg_bank_read_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, req_valid, rsp_ready;
    logic [2:0] wr_addr, req_addr;
    logic [7:0] wr_data;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_data;

    logic       d6_wr_en, d6_req_valid, d6_rsp_ready;
    logic [2:0] d6_wr_addr, d6_req_addr;
    logic [7:0] d6_wr_data;
    logic       d6_req_ready, d6_rsp_valid, d6_rsp_err;
    logic [7:0] d6_rsp_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_bank_read_responder u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    reg_bank_read_responder #(.DEPTH(6)) u_d6 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (d6_wr_en),
        .wr_addr   (d6_wr_addr),
        .wr_data   (d6_wr_data),
        .req_valid (d6_req_valid),
        .req_ready (d6_req_ready),
        .req_addr  (d6_req_addr),
        .rsp_valid (d6_rsp_valid),
        .rsp_ready (d6_rsp_ready),
        .rsp_data  (d6_rsp_data),
        .rsp_err   (d6_rsp_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: memory array plus the one buffered response, if any.
    logic [7:0] m_mem [8];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_err   = 1'b0;
        end else begin
            if (req_valid && (!m_valid || rsp_ready)) begin
                m_valid = 1'b1;
                m_err   = 1'b0;
                m_data  = m_mem[req_addr];
`ifdef REG_BANK_READ_FWD_EN
                if (wr_en && wr_addr == req_addr) m_data = wr_data;
`endif
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_req_ready", int'(req_ready), int'(!m_valid || rsp_ready));
            chk("cmp_rsp_valid", int'(rsp_valid), int'(m_valid));
            if (m_valid) begin
                chk("cmp_rsp_data", int'(rsp_data), int'(m_data));
                chk("cmp_rsp_err", int'(rsp_err), int'(m_err));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        req_valid = 0; req_addr = 0; rsp_ready = 0;
        d6_wr_en = 0; d6_wr_addr = 0; d6_wr_data = 0;
        d6_req_valid = 0; d6_req_addr = 0; d6_rsp_ready = 1;
        #12 reset = 1'b0;
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_data", int'(rsp_data), 0);
        chk("reset_err", int'(rsp_err), 0);

        req_valid = 1; req_addr = 3; rsp_ready = 1;
        cyc();
        req_valid = 0;
        chk("rd3_valid", int'(rsp_valid), 1);
        chk("rd3_data", int'(rsp_data), 8'h00);
        chk("rd3_err", int'(rsp_err), 0);

        wr_en = 1; wr_addr = 2; wr_data = 8'hA5;
        cyc();
        wr_en = 0; req_valid = 1; req_addr = 2;
        cyc();
        req_valid = 0;
        chk("rd2_data", int'(rsp_data), 8'hA5);

        wr_en = 1; wr_addr = 1; wr_data = 8'h11;
        cyc();
        wr_addr = 0; wr_data = 8'h77;
        cyc();
        wr_en = 0; req_valid = 1; req_addr = 1; rsp_ready = 0;
        cyc();
        req_addr = 0; wr_en = 1; wr_addr = 1; wr_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            chk("stall_ready", int'(req_ready), 0);
            chk("stall_data", int'(rsp_data), 8'h11);
            cyc();
        end
        wr_en = 0; rsp_ready = 1;
        cyc();
        req_valid = 0;
        chk("after_stall_data", int'(rsp_data), 8'h77);
        req_valid = 1; req_addr = 1;
        cyc();
        req_valid = 0;
        chk("rd1_new", int'(rsp_data), 8'h22);

        wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 3'(i); wr_data = 8'hC0 + 8'(i);
            cyc();
        end
        wr_en = 0; req_valid = 1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 3'(i);
            cyc();
            chk("b2b_valid", int'(rsp_valid), 1);
            chk("b2b_data", int'(rsp_data), 8'hC0 + i);
        end
        req_valid = 0;
        cyc();

        wr_en = 1; wr_addr = 5; wr_data = 8'h10;
        cyc();
        wr_data = 8'h3C; req_valid = 1; req_addr = 5;
        cyc();
        wr_en = 0; req_valid = 0;
`ifdef REG_BANK_READ_FWD_EN
        chk("same_cyc_fwd", int'(rsp_data), 8'h3C);
`else
        chk("same_cyc_rdfirst", int'(rsp_data), 8'h10);
`endif
        cyc();
        req_valid = 1;
        cyc();
        req_valid = 0;
        chk("wr5_done", int'(rsp_data), 8'h3C);

        rsp_ready = 0; req_valid = 1; req_addr = 2;
        cyc();
        req_valid = 0;
        chk("pre_rst_valid", int'(rsp_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", int'(rsp_valid), 0);
        chk("mid_rst_data", int'(rsp_data), 0);
        #3 reset = 1'b0;
        rsp_ready = 1;
        cyc();
        chk("post_rst_valid", int'(rsp_valid), 0);

        d6_wr_en = 1; d6_wr_addr = 7; d6_wr_data = 8'h55;
        cyc();
        d6_wr_addr = 5; d6_wr_data = 8'h66;
        cyc();
        d6_wr_en = 0; d6_req_valid = 1; d6_req_addr = 7;
        cyc();
        chk("d6_a7_valid", int'(d6_rsp_valid), 1);
        chk("d6_a7_err", int'(d6_rsp_err), 1);
        chk("d6_a7_data", int'(d6_rsp_data), 0);
        d6_req_addr = 5;
        cyc();
        chk("d6_a5_err", int'(d6_rsp_err), 0);
        chk("d6_a5_data", int'(d6_rsp_data), 8'h66);
        d6_req_addr = 6;
        cyc();
        chk("d6_a6_err", int'(d6_rsp_err), 1);
        chk("d6_a6_data", int'(d6_rsp_data), 0);
        d6_req_addr = 0;
        cyc();
        chk("d6_a0_data", int'(d6_rsp_data), 0);
        chk("d6_a0_err", int'(d6_rsp_err), 0);
        d6_req_valid = 0;
        cyc();
        chk("d6_idle", int'(d6_rsp_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
